// File: rtl/debounce_pkg.sv
// debounce_pkg: definitions shared by the debounce bank.
//   chan_state_e : per-channel state encoding (IDLE, LOCKOUT)
//   cnt_width()  : bits needed to hold 0..max_val, never less than 1
//   max_int()    : larger of two ints, used to size the shared hold counter
package debounce_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_LOCKOUT = 1'b1
    } chan_state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// debounce_bank_if: per-channel pin and event bundle of the debounce bank.
//   bit_in     : raw asynchronous inputs (pin side -> debouncer)
//   bit_out    : debounced levels
//   press      : one-cycle pulse on a 0->1 change of bit_out
//   release_ev : one-cycle pulse on a 1->0 change of bit_out
//   repeat_ev  : one-cycle auto-repeat pulse while held
// master = pin/consumer side, slave = debouncer side.
interface debounce_bank_if #(
    parameter int CHANNELS = 1
);
    logic [CHANNELS-1:0] bit_in;
    logic [CHANNELS-1:0] bit_out;
    logic [CHANNELS-1:0] press;
    logic [CHANNELS-1:0] release_ev;
    logic [CHANNELS-1:0] repeat_ev;

    modport master (output bit_in, input bit_out, press, release_ev, repeat_ev);
    modport slave  (input bit_in, output bit_out, press, release_ev, repeat_ev);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: one debounced input.
//   2-flop synchroniser -> IDLE/LOCKOUT acceptance FSM -> registered
//   level and press/release pulses. With DEBOUNCE_REPEAT_EN defined a hold
//   counter adds auto-repeat pulses while the level is high; otherwise
//   repeat_o is tied low.
// Ports:
//   clk, reset_low : clock, async active-low reset
//   bit_i          : raw asynchronous input
//   bit_o          : debounced level
//   press_o        : 0->1 event pulse
//   release_o      : 1->0 event pulse
//   repeat_o       : auto-repeat pulse
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CYCLES        = 0,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 0
) (
    input  logic clk,
    input  logic reset_low,
    input  logic bit_i,
    output logic bit_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int CW = cnt_width(CYCLES);

    if (CYCLES < 0) begin : g_bad_cycles
        $error("debounce_channel: CYCLES must be >= 0");
    end

    logic          sync1_q, synced_q;
    chan_state_e   state_q, state_d;
    logic [CW-1:0] lock_q, lock_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            sync1_q  <= 1'b0;
            synced_q <= 1'b0;
            state_q  <= ST_IDLE;
            lock_q   <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync1_q  <= bit_i;
            synced_q <= sync1_q;
            state_q  <= state_d;
            lock_q   <= lock_d;
            level_q  <= level_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
        end
    end

    // Acceptance compares against the current debounced level, so a change
    // that outlives the lockout window is taken on the first IDLE cycle.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (synced_q != level_q) begin
                    level_d = synced_q;
                    press_d = synced_q;
                    rel_d   = ~synced_q;
                    if (CYCLES != 0) begin
                        lock_d  = CW'(CYCLES);
                        state_d = ST_LOCKOUT;
                    end
                end
            end
            ST_LOCKOUT: begin
                // Leave on the edge the count hits 0 so the next acceptance
                // lands exactly CYCLES+1 edges after the previous one.
                lock_d = lock_q - CW'(1);
                if (lock_q <= CW'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bit_o     = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int HW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [HW-1:0] hold_q, hold_d;
    logic          rpt_q, rpt_d;

    // Pulse is registered on the edge the count would reach 0, i.e.
    // REPEAT_DELAY edges after the press. Press and release take priority,
    // which keeps repeat off the press cycle and silences it on release.
    always_comb begin
        hold_d = hold_q;
        rpt_d  = 1'b0;
        if (press_d) begin
            hold_d = HW'(REPEAT_DELAY);
        end else if (rel_d) begin
            hold_d = '0;
        end else if (level_q && hold_q != '0) begin
            if (hold_q == HW'(1)) begin
                rpt_d  = 1'b1;
                hold_d = HW'(REPEAT_PERIOD);
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            hold_q <= '0;
            rpt_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rpt_q  <= rpt_d;
        end
    end

    assign repeat_o = rpt_q;
`else
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be >= 0");
    end

    assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: CHANNELS independent debouncers for front-panel inputs.
// Optional auto-repeat is compiled in with `define DEBOUNCE_REPEAT_EN.
// Ports:
//   clk       : single clock
//   reset_low : async active-low reset, clears all state
//   bus       : debounce_bank_if.slave (bit_in in; bit_out, press,
//               release_ev, repeat_ev out; one bit per channel)
module debounce_bank #(
    parameter int CHANNELS      = 1,
    parameter int CYCLES        = 0,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 0
) (
    input  logic            clk,
    input  logic            reset_low,
    debounce_bank_if.slave  bus
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("debounce_bank: CHANNELS must be >= 1");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        debounce_channel #(
            .CYCLES        (CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .reset_low (reset_low),
            .bit_i     (bus.bit_in[c]),
            .bit_o     (bus.bit_out[c]),
            .press_o   (bus.press[c]),
            .release_o (bus.release_ev[c]),
            .repeat_o  (bus.repeat_ev[c])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed bench for debounce_bank.
// dut  : 4 channels, lockout 8, repeat 20/5.
// dut0 : 1 channel, no lockout.
// A time-indexed model predicts every output on every cycle; directed
// checks pin the model with hand-computed values.
module tb_debounce_bank;

    localparam int CH  = 4;
    localparam int CYC = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_low = 1'b0;
    always #5 clk = ~clk;

    debounce_bank_if #(.CHANNELS(CH)) bus ();
    debounce_bank_if #(.CHANNELS(1))  bus0 ();

    debounce_bank #(.CHANNELS(CH), .CYCLES(CYC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset_low(reset_low), .bus(bus));

    debounce_bank #(.CHANNELS(1), .CYCLES(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut0 (
        .clk(clk), .reset_low(reset_low), .bus(bus0));

    int checks = 0;
    int failures = 0;

    // Model: an input seen at edge n-2 is accepted at edge n if more than
    // cyc edges have passed since the last acceptance and it differs from
    // the level. Repeats fall at press+RD+k*RP while the level stays high.
    typedef struct {
        int n;
        int last_acc;
        int press_n;
        bit h1, h2;
        bit lvl, pr, rl, rp;
    } mdl_t;

    mdl_t m [CH+1];   // index CH models dut0

    function automatic void mdl_clear(output mdl_t x);
        x.n = 0; x.last_acc = -1000; x.press_n = -1000;
        x.h1 = 0; x.h2 = 0; x.lvl = 0; x.pr = 0; x.rl = 0; x.rp = 0;
    endfunction

    function automatic void mdl_step(inout mdl_t x, input bit din, input int cyc);
        bit seen;
        seen = x.h2;
        x.n++;
        x.pr = 0; x.rl = 0; x.rp = 0;
        if ((x.n - x.last_acc > cyc) && (seen != x.lvl)) begin
            x.lvl = seen;
            x.last_acc = x.n;
            if (seen) begin x.pr = 1; x.press_n = x.n; end
            else x.rl = 1;
        end
        if (REP_ON && x.lvl && !x.pr && (x.n - x.press_n >= RD) &&
            ((x.n - x.press_n - RD) % RP == 0))
            x.rp = 1;
        x.h2 = x.h1;
        x.h1 = din;
    endfunction

    always @(posedge clk or negedge reset_low) begin
        mdl_t t;
        for (int i = 0; i <= CH; i++) begin
            if (!reset_low) mdl_clear(t);
            else begin
                t = m[i];
                if (i < CH) mdl_step(t, bus.bit_in[i], CYC);
                else        mdl_step(t, bus0.bit_in[0], 0);
            end
            m[i] <= t;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i <= CH; i++) begin
            logic [3:0] act, req;
            if (i < CH) act = {bus.bit_out[i], bus.press[i], bus.release_ev[i], bus.repeat_ev[i]};
            else        act = {bus0.bit_out[0], bus0.press[0], bus0.release_ev[0], bus0.repeat_ev[0]};
            req = {m[i].lvl, m[i].pr, m[i].rl, m[i].rp};
            checks++;
            if (act !== req) begin
                failures++;
                $display("FAIL model_ch%0d t=%0t actual(out,pr,rl,rp)=%b required=%b", i, $time, act, req);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int np, nr, nrep;
        bit v, pv;
        bus.bit_in  = '0;
        bus0.bit_in = '0;
        reset_low   = 1'b0;
        tick(3);
        chk("reset_out",  32'(bus.bit_out), 0);
        chk("reset_pr",   32'(bus.press), 0);
        chk("reset_rl",   32'(bus.release_ev), 0);
        chk("reset_rp",   32'(bus.repeat_ev), 0);
        chk("reset_out0", 32'(bus0.bit_out), 0);
        reset_low = 1'b1;
        tick(2);

        // clean step on ch0
        bus.bit_in[0] = 1'b1;
        tick(2);
        chk("step_early", 32'(bus.bit_out), 0);
        tick(1);
        chk("step_press", 32'(bus.press), 32'h1);
        chk("step_out",   32'(bus.bit_out), 32'h1);
        tick(1);
        chk("step_press_end", 32'(bus.press), 0);
        chk("step_out_hold",  32'(bus.bit_out), 32'h1);

        // bounce on ch1
        np = 0; nr = 0;
        for (int i = 0; i < 5; i++) begin
            bus.bit_in[1] = (i % 2 == 0);
            tick(1);
            np += int'(bus.press[1]); nr += int'(bus.release_ev[1]);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1);
            np += int'(bus.press[1]); nr += int'(bus.release_ev[1]);
        end
        chk("bounce_press_cnt", 32'(np), 1);
        chk("bounce_rel_cnt",   32'(nr), 0);
        chk("bounce_out",       32'(bus.bit_out[1]), 1);

        // late change inside lockout on ch2
        bus.bit_in[2] = 1'b1;
        tick(3);
        chk("late_press", 32'(bus.press[2]), 1);
        tick(1);
        bus.bit_in[2] = 1'b0;
        tick(7);
        chk("late_rel_early", 32'(bus.release_ev[2]), 0);
        chk("late_out_hold",  32'(bus.bit_out[2]), 1);
        tick(1);
        chk("late_release", 32'(bus.release_ev[2]), 1);
        chk("late_out",     32'(bus.bit_out[2]), 0);

        // auto-repeat on ch3: held 40 clocks
        nrep = 0; nr = 0;
        bus.bit_in[3] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            nrep += int'(bus.repeat_ev[3]);
        end
        chk("repeat_cnt", 32'(nrep), REP_ON ? 4 : 0);
        bus.bit_in[3] = 1'b0;
        nrep = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            nrep += int'(bus.repeat_ev[3]); nr += int'(bus.release_ev[3]);
        end
        chk("repeat_after_rel", 32'(nrep), 0);
        chk("repeat_rel_cnt",   32'(nr), 1);

        // reset in the middle of a lockout
        bus.bit_in = '0;
        tick(15);
        chk("quiet_out", 32'(bus.bit_out), 0);
        bus.bit_in[0] = 1'b1;
        tick(3);
        chk("rst_press", 32'(bus.press), 32'h1);
        tick(3);
        reset_low = 1'b0;
        #1;
        chk("rst_async_out", 32'(bus.bit_out), 0);
        chk("rst_async_pr",  32'(bus.press), 0);
        tick(2);
        reset_low = 1'b1;
        tick(2);
        chk("rst_no_early", 32'(bus.press), 0);
        tick(1);
        chk("rst_repress", 32'(bus.press), 32'h1);
        tick(1);
        chk("rst_repress_end", 32'(bus.press), 0);
        chk("rst_out",         32'(bus.bit_out), 32'h1);

        // no-lockout instance: toggle every 2 clocks
        v = 1'b0; pv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = ~v;
            bus0.bit_in[0] = v;
            tick(1);
            if (i > 0) begin
                chk("c0_out",   32'(bus0.bit_out[0]), 32'(pv));
                chk("c0_press", 32'(bus0.press[0]), 32'(pv));
                chk("c0_rel",   32'(bus0.release_ev[0]), 32'(!pv));
            end
            pv = v;
            tick(1);
        end
        tick(1);
        chk("c0_out_last", 32'(bus0.bit_out[0]), 32'(pv));
        chk("c0_rel_last", 32'(bus0.release_ev[0]), 32'(!pv));

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
